spi_multi_master: RTL and testbench

//  Parametrised SPI master that serves N_DEV slave devices (DACs, ADC config ports) over a single shared SCK/MOSI bus.
//  - One-hot active-low chip selects driven internally.
//  - Per-transaction bit count and mode (CPOL/CPHA); full-duplex readback.
//  - Sits between the register interface and the board pins.
//  - Replaces per-device spi_master instances and their req-derived CS glue.

---
 rtl/spi_multi_master_pkg.sv | 16 +
 rtl/spi_multi_master_sclk_gen.sv | 38 +++
 rtl/spi_multi_master.sv | 114 +++++++++++
 tb/tb_spi_multi_master.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/spi_multi_master_pkg.sv
// spi_multi_master_pkg: FSM state encodings, widths and a width helper shared by the SPI master.
package spi_multi_master_pkg;
   localparam int NB_W = 8;
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] SETUP   = 3'd1;
   localparam logic [2:0] SHIFT   = 3'd2;
   localparam logic [2:0] HOLD    = 3'd3;
   localparam logic [2:0] DONE    = 3'd4;
   localparam logic [2:0] RELEASE = 3'd5;
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction
endpackage

// File: rtl/spi_multi_master_sclk_gen.sv
// spi_multi_master_sclk_gen: half-period divider producing lead/trail SCK edge strobes and a bit count.
module spi_multi_master_sclk_gen
   import spi_multi_master_pkg::*;
#(
   parameter int CLK_DIV = 30
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   output logic            lead_edge,
   output logic            trail_edge,
   output logic [NB_W-1:0] bit_cnt
);
   localparam int CW = clog2(CLK_DIV);
   logic [CW-1:0] cnt;
   logic          half;
   logic          wrap;
   assign wrap       = en && cnt == CW'(CLK_DIV - 1);
   assign lead_edge  = wrap && !half;
   assign trail_edge = wrap && half;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         half    <= 1'b0;
         bit_cnt <= '0;
      end else if (!en) begin
         cnt     <= '0;
         half    <= 1'b0;
         bit_cnt <= '0;
      end else if (wrap) begin
         cnt     <= '0;
         half    <= ~half;
         bit_cnt <= half ? bit_cnt + 1'b1 : bit_cnt;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/spi_multi_master.sv
// spi_multi_master: shared-bus SPI master with one-hot active-low selects, per-transfer length/mode and readback.
module spi_multi_master
   import spi_multi_master_pkg::*;
#(
   parameter int N_DEV    = 4,
   parameter int DW       = 24,
   parameter int CLK_DIV  = 30,
   parameter int CS_SETUP = 16,
   parameter int CS_HOLD  = 16,
   parameter int SEL_W    = clog2(N_DEV)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [SEL_W-1:0] sel,
   input  logic [NB_W-1:0]  nb,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [DW-1:0]    wr_data,
   output logic             ack,
   output logic             err,
   output logic             busy,
   output logic [DW-1:0]    rd_data,
   output logic             sclk,
   output logic             mosi,
   output logic [N_DEV-1:0] cs_n,
   input  logic [N_DEV-1:0] miso
);
   logic [2:0]       state;
   logic [SEL_W-1:0] sel_q;
   logic [NB_W-1:0]  nb_q, nb_eff, bit_cnt;
   logic             cpha_q, err_q, bad;
   logic [DW-1:0]    sh, aligned;
   logic [15:0]      tmr;
   logic             lead_edge, trail_edge, last, upd, smp, miso_bit;
   logic [N_DEV-1:0] cs_dec;
   spi_multi_master_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clk(clk), .rst(rst), .en(state == SHIFT),
      .lead_edge(lead_edge), .trail_edge(trail_edge), .bit_cnt(bit_cnt)
   );
   assign nb_eff  = (nb == '0 || 32'(nb) > DW) ? NB_W'(DW) : nb;
   assign aligned = wr_data << (DW - 32'(nb_eff));
   assign bad     = 32'(sel) >= N_DEV;
   assign last    = trail_edge && bit_cnt == nb_q - NB_W'(1);
   assign upd     = cpha_q ? lead_edge : trail_edge && !last;
   assign smp     = cpha_q ? trail_edge : lead_edge;
   assign ack     = state == DONE;
   assign err     = ack && err_q;
   assign busy    = state != IDLE;
   always_comb begin
      cs_dec   = '1;
      miso_bit = 1'b0;
      for (int i = 0; i < N_DEV; i++) begin
         cs_dec[i] = sel != SEL_W'(i);
         miso_bit  = (sel_q == SEL_W'(i)) ? miso[i] : miso_bit;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         sel_q   <= '0;
         nb_q    <= '0;
         cpha_q  <= 1'b0;
         err_q   <= 1'b0;
         sh      <= '0;
         tmr     <= '0;
         rd_data <= '0;
         sclk    <= 1'b0;
         mosi    <= 1'b0;
         cs_n    <= '1;
      end else begin
         case (state)
            IDLE: if (req) begin
               sel_q   <= sel;
               nb_q    <= nb_eff;
               cpha_q  <= cpha;
               err_q   <= bad;
               rd_data <= '0;
               tmr     <= '0;
               state   <= bad ? DONE : SETUP;
               if (!bad) begin
                  cs_n <= cs_dec;
                  sclk <= cpol;
                  sh   <= cpha ? aligned : aligned << 1;
                  mosi <= cpha ? mosi : aligned[DW-1];
               end
            end
            SETUP: begin
               tmr   <= (tmr == 16'(CS_SETUP - 1)) ? '0 : tmr + 1'b1;
               state <= (tmr == 16'(CS_SETUP - 1)) ? SHIFT : SETUP;
            end
            SHIFT: begin
               if (lead_edge || trail_edge) sclk <= ~sclk;
               if (upd) begin
                  mosi <= sh[DW-1];
                  sh   <= sh << 1;
               end
               if (smp) rd_data <= {rd_data[DW-2:0], miso_bit};
               if (last) state <= HOLD;
            end
            HOLD: if (tmr == 16'(CS_HOLD - 1)) begin
               tmr   <= '0;
               state <= DONE;
               cs_n  <= '1;
            end else begin
               tmr <= tmr + 1'b1;
            end
            DONE:    state <= RELEASE;
            RELEASE: state <= req ? RELEASE : IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_spi_multi_master.sv
// tb_spi_multi_master: directed checks of timing, modes, readback, select errors, handshake and async reset.
module tb_spi_multi_master;
   logic        clk = 1'b0, rst = 1'b1, req = 1'b0, cpol = 1'b0, cpha = 1'b0;
   logic [2:0]  sel = '0;
   logic [7:0]  nb = '0;
   logic [23:0] wr_data = '0, rd_data;
   logic        ack, err, busy, sclk, mosi;
   logic [3:0]  cs_n, miso = '0;
   int          n_vec = 0, n_err = 0;

   spi_multi_master #(.SEL_W(3)) dut (
      .clk(clk), .rst(rst), .req(req), .sel(sel), .nb(nb), .cpol(cpol), .cpha(cpha),
      .wr_data(wr_data), .ack(ack), .err(err), .busy(busy), .rd_data(rd_data),
      .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso)
   );

   always #4 clk = ~clk;

   // Runs one transfer from edge 0; records ack cycle and bus activity, with a simple SPI slave on miso.
   task automatic xfer(input logic [2:0] s, input logic [7:0] n, input logic p, input logic h,
                       input logic [23:0] w, input logic [7:0] sd, input int drop_at,
                       output int ack_cyc, output logic e, output int tog, output logic [23:0] mb,
                       output int ns, output logic cs_bad, output logic sclk_first);
      logic [3:0] cs_exp;
      logic       prev;
      int         cyc, k;
      cs_exp = (s < 4) ? ~(4'b0001 << s[1:0]) : 4'hF;
      ack_cyc = -1; e = 1'b0; tog = 0; mb = '0; ns = 0; cs_bad = 1'b0; k = 0;
      @(negedge clk);
      sel = s; nb = n; cpol = p; cpha = h; wr_data = w; req = 1'b1; miso = '0;
      @(posedge clk); #1;
      cyc = 1;
      sclk_first = sclk;
      prev = sclk;
      if (!h && s < 4) begin
         miso[s[1:0]] = sd[7];
         k = 1;
      end
      while (cyc <= 3000) begin
         if (cyc == drop_at) req = 1'b0;
         if (ack) begin
            ack_cyc = cyc;
            e = err;
            break;
         end
         if (cs_n !== cs_exp) cs_bad = 1'b1;
         if (sclk !== prev) begin
            tog++;
            if (sclk == (p == h)) begin
               mb = {mb[22:0], mosi};
               ns++;
            end else if (s < 4 && k < 8) begin
               miso[s[1:0]] = sd[7-k];
               k++;
            end
         end
         prev = sclk;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic finish_req();
      req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL reset_ack got %b want 0", ack); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", err); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
      n_vec++; if (rd_data !== 24'h0) begin n_err++; $display("FAIL reset_rd_data got %h want 000000", rd_data); end
      n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL reset_sclk got %b want 0", sclk); end
      n_vec++; if (mosi !== 1'b0) begin n_err++; $display("FAIL reset_mosi got %b want 0", mosi); end
      n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL reset_cs_n got %h want F", cs_n); end
   endtask

   task automatic test_cpha0_write();
      int ac, tg, ns; logic e, cb, sf; logic [23:0] mb;
      xfer(3'd1, 8'd24, 1'b0, 1'b0, 24'hA5C3F0, 8'h00, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 1473) begin n_err++; $display("FAIL w_ack_cycle got %0d want 1473", ac); end
      n_vec++; if (e !== 1'b0) begin n_err++; $display("FAIL w_err got %b want 0", e); end
      n_vec++; if (cb !== 1'b0) begin n_err++; $display("FAIL w_cs_n not 1101 throughout"); end
      n_vec++; if (ns != 24) begin n_err++; $display("FAIL w_samples got %0d want 24", ns); end
      n_vec++; if (mb !== 24'hA5C3F0) begin n_err++; $display("FAIL w_mosi got %h want A5C3F0", mb); end
      n_vec++; if (tg != 48) begin n_err++; $display("FAIL w_toggles got %0d want 48", tg); end
      n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL w_cs_done got %h want F", cs_n); end
      @(posedge clk); #1;
      n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL w_ack_width got %b want 0", ack); end
      finish_req();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL w_busy_end got %b want 0", busy); end
   endtask

   task automatic test_readback();
      int ac, tg, ns; logic e, cb, sf; logic [23:0] mb;
      xfer(3'd2, 8'd8, 1'b1, 1'b1, 24'h00005A, 8'h3C, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 513) begin n_err++; $display("FAIL rb_ack_cycle got %0d want 513", ac); end
      n_vec++; if (rd_data !== 24'h00003C) begin n_err++; $display("FAIL rb_rd_data got %h want 00003C", rd_data); end
      n_vec++; if (tg != 16) begin n_err++; $display("FAIL rb_toggles got %0d want 16", tg); end
      n_vec++; if (sf !== 1'b1) begin n_err++; $display("FAIL rb_sclk_before got %b want 1", sf); end
      n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL rb_sclk_after got %b want 1", sclk); end
      n_vec++; if (mb[7:0] !== 8'h5A) begin n_err++; $display("FAIL rb_mosi got %h want 5A", mb[7:0]); end
      n_vec++; if (cb !== 1'b0) begin n_err++; $display("FAIL rb_cs_n not 1011 throughout"); end
      finish_req();
   endtask

   task automatic test_bad_select();
      int ac, tg, ns; logic e, cb, sf; logic [23:0] mb;
      xfer(3'd5, 8'd8, 1'b0, 1'b0, 24'h123456, 8'h00, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 1) begin n_err++; $display("FAIL bad_ack_cycle got %0d want 1", ac); end
      n_vec++; if (e !== 1'b1) begin n_err++; $display("FAIL bad_err got %b want 1", e); end
      n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL bad_cs_n got %h want F", cs_n); end
      n_vec++; if (sclk !== 1'b1) begin n_err++; $display("FAIL bad_sclk got %b want 1 (untouched)", sclk); end
      n_vec++; if (rd_data !== 24'h0) begin n_err++; $display("FAIL bad_rd_data got %h want 000000", rd_data); end
      finish_req();
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL bad_err_after got %b want 0", err); end
   endtask

   task automatic test_handshake();
      int ac, tg, ns, extra; logic e, cb, sf, bz; logic [23:0] mb;
      xfer(3'd0, 8'd8, 1'b0, 1'b0, 24'h0000C5, 8'hC5, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 513) begin n_err++; $display("FAIL hs_ack_cycle got %0d want 513", ac); end
      n_vec++; if (rd_data !== 24'h0000C5) begin n_err++; $display("FAIL hs_rd_data got %h want 0000C5", rd_data); end
      extra = 0; bz = 1'b1;
      repeat (2487) begin
         @(posedge clk); #1;
         if (ack) extra++;
         if (!busy) bz = 1'b0;
      end
      n_vec++; if (extra != 0) begin n_err++; $display("FAIL hs_extra_acks got %0d want 0", extra); end
      n_vec++; if (bz !== 1'b1) begin n_err++; $display("FAIL hs_busy_held got %b want 1", bz); end
      finish_req();
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_busy_release got %b want 0", busy); end
      xfer(3'd3, 8'd24, 1'b0, 1'b0, 24'h0F0F0F, 8'h00, 100, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 1473) begin n_err++; $display("FAIL hs_drop_ack got %0d want 1473", ac); end
      repeat (2) @(posedge clk); #1;
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL hs_drop_idle got %b want 0", busy); end
   endtask

   task automatic test_nb_limits();
      int ac, tg, ns; logic e, cb, sf; logic [23:0] mb;
      xfer(3'd0, 8'd0, 1'b0, 1'b0, 24'h81C3E7, 8'h00, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 1473) begin n_err++; $display("FAIL nb0_ack got %0d want 1473", ac); end
      n_vec++; if (mb !== 24'h81C3E7 || ns != 24) begin n_err++; $display("FAIL nb0_mosi got %h/%0d want 81C3E7/24", mb, ns); end
      finish_req();
      xfer(3'd1, 8'd30, 1'b0, 1'b0, 24'h7E3C18, 8'h00, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 1473) begin n_err++; $display("FAIL nb30_ack got %0d want 1473", ac); end
      n_vec++; if (mb !== 24'h7E3C18 || ns != 24) begin n_err++; $display("FAIL nb30_mosi got %h/%0d want 7E3C18/24", mb, ns); end
      finish_req();
   endtask

   task automatic test_async_reset();
      int ac, tg, ns, acks; logic e, cb, sf; logic [23:0] mb;
      @(negedge clk);
      sel = 3'd1; nb = 8'd24; cpol = 1'b0; cpha = 1'b0; wr_data = 24'hFFFFFF; req = 1'b1;
      @(posedge clk);
      repeat (499) @(posedge clk);
      #1;
      n_vec++; if (cs_n !== 4'b1101) begin n_err++; $display("FAIL ar_pre_cs_n got %h want D", cs_n); end
      #2 rst = 1'b1;
      #1;
      n_vec++; if (cs_n !== 4'hF) begin n_err++; $display("FAIL ar_cs_n got %h want F", cs_n); end
      n_vec++; if (sclk !== 1'b0) begin n_err++; $display("FAIL ar_sclk got %b want 0", sclk); end
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL ar_busy got %b want 0", busy); end
      req = 1'b0; acks = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      @(negedge clk) rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      n_vec++; if (acks != 0) begin n_err++; $display("FAIL ar_no_ack got %0d want 0", acks); end
      xfer(3'd2, 8'd8, 1'b0, 1'b0, 24'h0000A3, 8'h96, 0, ac, e, tg, mb, ns, cb, sf);
      n_vec++; if (ac != 513) begin n_err++; $display("FAIL ar_next_ack got %0d want 513", ac); end
      n_vec++; if (rd_data !== 24'h000096) begin n_err++; $display("FAIL ar_next_rd got %h want 000096", rd_data); end
      n_vec++; if (mb[7:0] !== 8'hA3) begin n_err++; $display("FAIL ar_next_mosi got %h want A3", mb[7:0]); end
      finish_req();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      #1;
      test_reset();
      test_cpha0_write();
      test_readback();
      test_bad_select();
      test_handshake();
      test_nb_limits();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
